// File: rtl/decoder_nto2n_seq_if.sv
// Request/response bundle for decoder_nto2n_seq: the request handshake plus the
// registered one-hot select and its status flags.
interface decoder_nto2n_seq_if #(
  parameter int SEL_W = 4
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             mode;
  logic             clear;
  logic [OUT_W-1:0] out_onehot;
  logic             out_valid;
  logic             busy;
  logic             scan_done;

  modport master (
    output in_valid, in_sel, mode, clear,
    input  in_ready, out_onehot, out_valid, busy, scan_done
  );

  modport slave (
    input  in_valid, in_sel, mode, clear,
    output in_ready, out_onehot, out_valid, busy, scan_done
  );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with dwell timer and auto-scan.
// Optional macro DECODER_ACTIVE_LOW_EN drives the select one-cold (all ones when idle).
module decoder_nto2n_seq #(
  parameter int SEL_W = 4,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_nto2n_seq_if.slave   bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] IDLE_CODE = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] IDLE_CODE = {OUT_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             in_ready_s;
  logic             accept_s;
  logic             done_s;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign in_ready_s = (state_q == IDLE) && !bus.clear;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign done_s     = (state_q == SCAN) && (cnt_q == {CNT_W{1'b0}}) && (idx_q == last_q);

  // Next-state logic; the output code is derived from the next index so a scan
  // step lands on the same edge as the dwell reload, with no gap cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
      idx_d   = {SEL_W{1'b0}};
      last_d  = {SEL_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            cnt_d = CNT_LOAD;
            if (bus.mode) begin
              state_d = SCAN;
              idx_d   = {SEL_W{1'b0}};
              last_d  = bus.in_sel;
            end else begin
              state_d = HOLD;
              idx_d   = bus.in_sel;
            end
          end else begin
            idx_d = {SEL_W{1'b0}};
          end
        end
        HOLD: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = IDLE;
            idx_d   = {SEL_W{1'b0}};
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SCAN: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (idx_q == last_q) begin
            state_d = IDLE;
            idx_d   = {SEL_W{1'b0}};
          end else begin
            idx_d = idx_q + SEL_W'(1);
            cnt_d = CNT_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {SEL_W{1'b0}};
        end
      endcase
    end
    if (state_d == IDLE) begin
      out_d = IDLE_CODE;
    end else begin
      out_d = onehot(idx_d) ^ IDLE_CODE;
    end
  end

  // State, dwell counter, scan index and output code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {SEL_W{1'b0}};
      last_q  <= {SEL_W{1'b0}};
      out_q   <= IDLE_CODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_onehot = out_q;
  assign bus.out_valid  = (state_q != IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.scan_done  = done_s;
endmodule
